// File: rtl/pushbutton_processor_v2.sv
// -----------------------------------------------------------------------------
// pushbutton_processor_v2
//
// Purpose:
//   Multi-channel pushbutton front end for the 1 kHz system tick. Each of the
//   NUM_BTN channels has its own synchroniser, debouncer and press-classification
//   FSM. The FSM turns a debounced press into exactly one of:
//     - a short event (released before LONG_TICKS), or
//     - a long event (held for LONG_TICKS), optionally followed by auto-repeat
//       events every REPEAT_TICKS while the button stays down.
//   Channels share nothing except clock and reset.
//
// Ports:
//   clk_1khz_i    system clock, all state on the rising edge
//   rst_n_i       synchronous active-low reset
//   pushbutton_i  raw asynchronous buttons, 1 = pressed, bit k = channel k
//   pressed_o     debounced level per channel (registered)
//   short_o       1-cycle pulse, press released before LONG_TICKS (registered)
//   long_o        1-cycle pulse, press held for LONG_TICKS (registered)
//   repeat_o      1-cycle pulse every REPEAT_TICKS after long_o while held
//                 (registered, only when REPEAT_EN != 0)
//
// Timing summary (relative to the pressed_o rise):
//   long_o    at LONG_TICKS
//   repeat_o  at LONG_TICKS + n*REPEAT_TICKS, n >= 1, while still held
//   short_o   in the same cycle pressed_o falls
// -----------------------------------------------------------------------------
module pushbutton_processor_v2 #(
  parameter int unsigned NUM_BTN        = 2,
  parameter int unsigned DEBOUNCE_TICKS = 20,
  parameter int unsigned LONG_TICKS     = 1500,
  parameter int unsigned REPEAT_EN      = 1,
  parameter int unsigned REPEAT_TICKS   = 250
) (
  input  logic               clk_1khz_i,
  input  logic               rst_n_i,
  input  logic [NUM_BTN-1:0] pushbutton_i,
  output logic [NUM_BTN-1:0] pressed_o,
  output logic [NUM_BTN-1:0] short_o,
  output logic [NUM_BTN-1:0] long_o,
  output logic [NUM_BTN-1:0] repeat_o
);

  localparam int unsigned DebW  = $clog2(DEBOUNCE_TICKS + 1);
  localparam int unsigned HoldW = $clog2(LONG_TICKS + 1);
  localparam int unsigned RepW  = $clog2(REPEAT_TICKS + 1);

  localparam logic [DebW-1:0]  DebLast  = DebW'(DEBOUNCE_TICKS - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_TICKS - 1);
  localparam logic [RepW-1:0]  RepLast  = RepW'(REPEAT_TICKS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StHeld,
    StLong,
    StRepeat
  } state_e;

  for (genvar k = 0; k < NUM_BTN; k++) begin : g_chan

    // Synchroniser
    logic sync1_q;
    logic sync2_q;

    // Debouncer
    logic [DebW-1:0] deb_cnt_q, deb_cnt_d;
    logic            pressed_q, pressed_d;
    logic            rise;
    logic            fall;

    // Classification FSM
    state_e           state_q, state_d;
    logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
    logic [RepW-1:0]  rep_cnt_q, rep_cnt_d;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             repeat_q, repeat_d;

    always_ff @(posedge clk_1khz_i) begin
      if (!rst_n_i) begin
        sync1_q    <= 1'b0;
        sync2_q    <= 1'b0;
        deb_cnt_q  <= '0;
        pressed_q  <= 1'b0;
        state_q    <= StIdle;
        hold_cnt_q <= '0;
        rep_cnt_q  <= '0;
        short_q    <= 1'b0;
        long_q     <= 1'b0;
        repeat_q   <= 1'b0;
      end else begin
        sync1_q    <= pushbutton_i[k];
        sync2_q    <= sync1_q;
        deb_cnt_q  <= deb_cnt_d;
        pressed_q  <= pressed_d;
        state_q    <= state_d;
        hold_cnt_q <= hold_cnt_d;
        rep_cnt_q  <= rep_cnt_d;
        short_q    <= short_d;
        long_q     <= long_d;
        repeat_q   <= repeat_d;
      end
    end

    // Count consecutive cycles of disagreement between the synchronised input
    // and the accepted level; any agreement restarts the count. The level flips
    // on the DEBOUNCE_TICKS-th consecutive disagreeing cycle.
    always_comb begin
      deb_cnt_d = '0;
      pressed_d = pressed_q;
      if (sync2_q != pressed_q) begin
        if (deb_cnt_q == DebLast) begin
          pressed_d = ~pressed_q;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end
    end

    // Edges are taken from the next-state level so that the FSM's registered
    // pulses line up with the registered pressed_o transition.
    assign rise = pressed_d & ~pressed_q;
    assign fall = ~pressed_d & pressed_q;

    always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      rep_cnt_d  = rep_cnt_q;
      short_d    = 1'b0;
      long_d     = 1'b0;
      repeat_d   = 1'b0;

      case (state_q)
        StIdle: begin
          if (rise) begin
            state_d    = StHeld;
            hold_cnt_d = '0;
          end
        end

        StHeld: begin
          // Reaching the long threshold wins over a release in the same cycle,
          // so a press lasting exactly LONG_TICKS is classified long.
          if (hold_cnt_q == HoldLast) begin
            long_d    = 1'b1;
            state_d   = StLong;
            rep_cnt_d = '0;
          end else if (fall) begin
            short_d = 1'b1;
            state_d = StIdle;
          end else if (hold_cnt_q < HoldLast) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end

        StLong, StRepeat: begin
          // Level test rather than edge: the release may already have happened
          // in the cycle the long event was issued.
          if (!pressed_d) begin
            state_d = StIdle;
          end else if (REPEAT_EN != 0) begin
            state_d = StRepeat;
            if (rep_cnt_q == RepLast) begin
              repeat_d  = 1'b1;
              rep_cnt_d = '0;
            end else begin
              rep_cnt_d = rep_cnt_q + 1'b1;
            end
          end
        end

        default: state_d = StIdle;
      endcase
    end

    assign pressed_o[k] = pressed_q;
    assign short_o[k]   = short_q;
    assign long_o[k]    = long_q;
    assign repeat_o[k]  = repeat_q;

  end : g_chan

endmodule

// File: tb/tb_pushbutton_processor_v2.sv
// -----------------------------------------------------------------------------
// Bench for pushbutton_processor_v2. Two instances share stimulus: one with
// auto-repeat enabled, one with it disabled. Every observable event (pressed
// rise/fall, short, long, repeat) is matched against a time-ordered queue of
// expected events built from the press schedule before it is driven.
// Scoreboard channel index = instance*2 + button (instance 0 = repeat enabled).
// Event kinds: 0 pressed rise, 1 pressed fall, 2 short, 3 long, 4 repeat.
// -----------------------------------------------------------------------------
module tb_pushbutton_processor_v2;

  localparam int Deb  = 20;
  localparam int Long = 1500;
  localparam int Rep  = 250;
  localparam int Lat  = Deb + 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] pb;

  logic [1:0] pr_r, sh_r, lg_r, rp_r;
  logic [1:0] pr_n, sh_n, lg_n, rp_n;
  logic [3:0] pr_all, sh_all, lg_all, rp_all;
  logic [3:0] prev_pr = '0;

  int     total = 0;
  int     bad   = 0;
  int     cyc   = 0;
  longint exp_q[$];

  assign pr_all = {pr_n, pr_r};
  assign sh_all = {sh_n, sh_r};
  assign lg_all = {lg_n, lg_r};
  assign rp_all = {rp_n, rp_r};

  pushbutton_processor_v2 #(
    .NUM_BTN(2), .DEBOUNCE_TICKS(Deb), .LONG_TICKS(Long), .REPEAT_EN(1), .REPEAT_TICKS(Rep)
  ) dut_rep (
    .clk_1khz_i(clk), .rst_n_i(rst_n), .pushbutton_i(pb),
    .pressed_o(pr_r), .short_o(sh_r), .long_o(lg_r), .repeat_o(rp_r)
  );

  pushbutton_processor_v2 #(
    .NUM_BTN(2), .DEBOUNCE_TICKS(Deb), .LONG_TICKS(Long), .REPEAT_EN(0), .REPEAT_TICKS(Rep)
  ) dut_norep (
    .clk_1khz_i(clk), .rst_n_i(rst_n), .pushbutton_i(pb),
    .pressed_o(pr_n), .short_o(sh_n), .long_o(lg_n), .repeat_o(rp_n)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push_ev(int c, int ch, int kind);
    longint key;
    int     i;
    key = longint'(c) * 64 + longint'(ch * 8 + kind);
    i = 0;
    while (i < exp_q.size() && exp_q[i] <= key) i++;
    exp_q.insert(i, key);
  endfunction

  // Input goes high between edges c0 and c0+1 and stays high len cycles.
  function automatic void expect_press(int ch, int c0, int len);
    int r;
    int f;
    r = c0 + Lat;
    f = c0 + len + Lat;
    for (int inst = 0; inst < 2; inst++) begin
      push_ev(r, inst * 2 + ch, 0);
      push_ev(f, inst * 2 + ch, 1);
      if (len < Long) begin
        push_ev(f, inst * 2 + ch, 2);
      end else begin
        push_ev(r + Long, inst * 2 + ch, 3);
        if (inst == 0) begin
          for (int e = r + Long + Rep; e < f; e += Rep) push_ev(e, inst * 2 + ch, 4);
        end
      end
    end
  endfunction

  // Scoreboard consumer: every observed event must be the next expected one.
  initial begin
    logic   hit;
    longint key;
    longint e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        for (int c = 0; c < 4; c++) begin
          for (int k = 0; k < 5; k++) begin
            case (k)
              0:       hit = pr_all[c] & ~prev_pr[c];
              1:       hit = ~pr_all[c] & prev_pr[c];
              2:       hit = sh_all[c];
              3:       hit = lg_all[c];
              default: hit = rp_all[c];
            endcase
            if (hit === 1'b1) begin
              key = longint'(cyc) * 64 + longint'(c * 8 + k);
              total++;
              if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event got cyc=%0d ch=%0d kind=%0d expected none",
                         cyc, c, k);
              end else begin
                e = exp_q.pop_front();
                if (e != key) begin
                  bad++;
                  $display("FAIL event_match got cyc=%0d ch=%0d kind=%0d expected cyc=%0d ch=%0d kind=%0d",
                           cyc, c, k, e / 64, (e / 8) % 8, e % 8);
                end
              end
            end
          end
        end
      end
      prev_pr = pr_all;
    end
  end

  task automatic check_drained(input string name);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s missing_events got=0 expected=%0d next cyc=%0d ch=%0d kind=%0d",
               name, exp_q.size(), exp_q[0] / 64, (exp_q[0] / 8) % 8, exp_q[0] % 8);
      exp_q.delete();
    end
  endtask

  // Drives one optional press per button over an n-cycle window; expectations
  // are queued before the first cycle is driven. Entered #1 after a posedge.
  task automatic run_window(input int st0, input int len0, input int st1, input int len1,
                            input int n);
    int base;
    base = cyc;
    if (len0 > 0) expect_press(0, base + st0, len0);
    if (len1 > 0) expect_press(1, base + st1, len1);
    for (int t = 0; t < n; t++) begin
      pb[0] = (len0 > 0) && (t >= st0) && (t < st0 + len0);
      pb[1] = (len1 > 0) && (t >= st1) && (t < st1 + len1);
      @(posedge clk);
      #1;
    end
    pb = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pb    = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({pr_n, pr_r} !== 4'b0) begin
      bad++; $display("FAIL reset_pressed got=%b expected=0000", {pr_n, pr_r});
    end
    total++;
    if ({sh_n, sh_r} !== 4'b0) begin
      bad++; $display("FAIL reset_short got=%b expected=0000", {sh_n, sh_r});
    end
    total++;
    if ({lg_n, lg_r} !== 4'b0) begin
      bad++; $display("FAIL reset_long got=%b expected=0000", {lg_n, lg_r});
    end
    total++;
    if ({rp_n, rp_r} !== 4'b0) begin
      bad++; $display("FAIL reset_repeat got=%b expected=0000", {rp_n, rp_r});
    end
    rst_n = 1'b1;
    pb    = 2'b00;
    run_window(0, 0, 0, 0, 40);
    check_drained("reset_idle");
  endtask

  task automatic test_short();
    run_window(0, 100, 0, 0, 160);
    check_drained("short_press");
  endtask

  task automatic test_bounce();
    for (int t = 0; t < 30; t++) begin
      pb[0] = ((t / 3) % 2) == 0;
      pb[1] = 1'b0;
      @(posedge clk);
      #1;
      total++;
      if (pr_r[0] !== 1'b0) begin
        bad++; $display("FAIL bounce_level t=%0d got=%b expected=0", t, pr_r[0]);
      end
    end
    pb = '0;
    run_window(0, 0, 0, 0, 60);
    check_drained("bounce");
  endtask

  task automatic test_long_hold();
    run_window(0, 0, 0, 2100, 2160);
    check_drained("long_hold");
  endtask

  task automatic test_boundary();
    run_window(0, Long - 1, 0, 0, Long + 60);
    check_drained("boundary_short");
    run_window(0, Long, 0, 0, Long + 60);
    check_drained("boundary_long");
  endtask

  task automatic test_concurrency();
    run_window(50, 100, 0, 1600, 1660);
    check_drained("concurrent_offset");
    run_window(0, 100, 0, 100, 160);
    check_drained("concurrent_short_aligned");
    run_window(0, Long, 0, Long, Long + 60);
    check_drained("concurrent_long_aligned");
  endtask

  task automatic test_reset_mid_hold();
    int base;
    base = cyc;
    push_ev(base + Lat, 0, 0);
    push_ev(base + Lat, 2, 0);
    pb = 2'b01;
    repeat (Lat + 1000) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      total++;
      if ({pr_all, sh_all, lg_all, rp_all} !== 16'b0) begin
        bad++;
        $display("FAIL reset_mid_hold_outputs got=%h expected=0000",
                 {pr_all, sh_all, lg_all, rp_all});
      end
    end
    check_drained("reset_mid_hold_pre");
    rst_n = 1'b1;
    run_window(0, 1600, 0, 0, 1660);
    check_drained("reset_mid_hold_post");
  endtask

  initial begin
    rst_n = 1'b0;
    pb    = '0;
    test_reset();
    test_short();
    test_bounce();
    test_long_hold();
    test_boundary();
    test_concurrency();
    test_reset_mid_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
